// File: rtl/grf_pkg.sv
// Shared definitions for the general register file: address geometry,
// architectural register names, default data width and trace tag layout.
package grf_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_ZERO   = 0;
  localparam int REG_RA     = 31;  // jal link register, highest stored index
  localparam int DATA_W_DEF = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Address/PC half of a committed-write trace record.
  typedef struct packed {
    logic [31:0] pc;
    reg_addr_t   addr;
  } trace_tag_t;

  // Register 0 is hardwired; every consumer tests for it the same way.
  function automatic logic addr_is_zero(input reg_addr_t a);
    return a == reg_addr_t'(REG_ZERO);
  endfunction

endpackage

// File: rtl/grf_if.sv
// Register-file bus: controller-side write/read requests plus the read data,
// commit trace and write counter returned by the register file.
interface grf_if
  import grf_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF
) ();

  logic             we;
  reg_addr_t        ra1;
  reg_addr_t        ra2;
  reg_addr_t        wa;
  logic [WIDTH-1:0] wd;
  logic [31:0]      pc;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             trace_valid;
  logic [31:0]      trace_pc;
  reg_addr_t        trace_addr;
  logic [WIDTH-1:0] trace_data;
  logic [31:0]      wr_count;

  // Controller side: issues addresses and write requests.
  modport master (
    output we, ra1, ra2, wa, wd, pc,
    input  rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data, wr_count
  );

  // Register-file side.
  modport slave (
    input  we, ra1, ra2, wa, wd, pc,
    output rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data, wr_count
  );

endinterface

// File: rtl/grf_read_port.sv
// One combinational read port: selects the stored register, forces register 0
// to zero and optionally forwards the write data of the current cycle.
module grf_read_port
  import grf_pkg::*;
#(
  parameter int WIDTH  = DATA_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input  reg_addr_t                      ra,
  input  logic                           fwd_en,
  input  reg_addr_t                      wa,
  input  logic [WIDTH-1:0]               wd,
  input  logic [NUM_REGS-1:1][WIDTH-1:0] regs,
  output logic [WIDTH-1:0]               rd
);

  logic [WIDTH-1:0] stored;
  logic             hit;

  // Stored-value mux; index 0 has no storage so it falls through to zero.
  always_comb begin
    stored = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ra == reg_addr_t'(i)) stored = regs[i];
    end
  end

  // fwd_en already excludes reset cycles, so forwarding never shows wd
  // while the write is being discarded.
  assign hit = BYPASS && fwd_en && (wa == ra) && !addr_is_zero(ra);

  // Final select: zero register dominates, then forwarding, then storage.
  always_comb begin
    if (addr_is_zero(ra)) begin
      rd = '0;
    end else if (hit) begin
      rd = wd;
    end else begin
      rd = stored;
    end
  end

endmodule

// File: rtl/grf.sv
// General register file: 31 stored registers (r0 hardwired to zero), two
// zero-latency read ports, a one-cycle commit trace and a write counter.
module grf
  import grf_pkg::*;
#(
  parameter int WIDTH  = DATA_W_DEF,
  parameter bit BYPASS = 1'b1
) (
  input logic  clk,
  input logic  reset,
  grf_if.slave bus
);

  logic [NUM_REGS-1:1][WIDTH-1:0] regs_q;
  logic                           commit;
  logic                           fwd_en;

  logic                           vld_p1;
  trace_tag_t                     tag_p1;
  logic [WIDTH-1:0]               tr_data_p1;
  logic [31:0]                    cnt_q;

  // A write only changes state when it targets r1..r31; r0 writes are
  // still traced but never stored or counted.
  assign commit = bus.we && !addr_is_zero(bus.wa);
  assign fwd_en = bus.we && reset;

  // Register storage; reset wipes every register and drops the pending write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q <= '0;
    end else begin
      for (int i = 1; i <= REG_RA; i++) begin
        if (commit && (bus.wa == reg_addr_t'(i))) regs_q[i] <= bus.wd;
      end
    end
  end

  // ---- stage p1: trace of the write accepted on the previous edge ----
  // Fields hold their last value while no write is traced.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      tag_p1     <= '0;
      tr_data_p1 <= '0;
    end else begin
      vld_p1 <= bus.we;
      if (bus.we) begin
        tag_p1     <= '{pc: bus.pc, addr: bus.wa};
        tr_data_p1 <= addr_is_zero(bus.wa) ? '0 : bus.wd;
      end
    end
  end

  // Committed-write counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (commit) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  grf_read_port #(
    .WIDTH  (WIDTH),
    .BYPASS (BYPASS)
  ) u_rp1 (
    .ra     (bus.ra1),
    .fwd_en (fwd_en),
    .wa     (bus.wa),
    .wd     (bus.wd),
    .regs   (regs_q),
    .rd     (bus.rd1)
  );

  grf_read_port #(
    .WIDTH  (WIDTH),
    .BYPASS (BYPASS)
  ) u_rp2 (
    .ra     (bus.ra2),
    .fwd_en (fwd_en),
    .wa     (bus.wa),
    .wd     (bus.wd),
    .regs   (regs_q),
    .rd     (bus.rd2)
  );

  assign bus.trace_valid = vld_p1;
  assign bus.trace_pc    = tag_p1.pc;
  assign bus.trace_addr  = tag_p1.addr;
  assign bus.trace_data  = tr_data_p1;
  assign bus.wr_count    = cnt_q;

endmodule

// File: tb/tb_grf.sv
// Self-checking bench for grf: a BYPASS=1 and a BYPASS=0 instance receive the
// same stimulus; a behavioural register-array model predicts every cycle and
// a monitor compares outputs on the falling edge.
module tb_grf;

  logic clk;
  logic reset;

  grf_if #(.WIDTH(32)) bus1 ();
  grf_if #(.WIDTH(32)) bus0 ();

  grf #(.WIDTH(32), .BYPASS(1'b1)) u_b1 (.clk(clk), .reset(reset), .bus(bus1));
  grf #(.WIDTH(32), .BYPASS(1'b0)) u_b0 (.clk(clk), .reset(reset), .bus(bus0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          chk;
    logic [31:0] r1_b1, r2_b1, r1_b0, r2_b0;
    bit          tv;
    logic [31:0] tpc;
    logic [4:0]  taddr;
    logic [31:0] tdata;
    logic [31:0] cnt;
  } exp_t;

  exp_t expq[$];

  // Reference model state: architectural view after the most recent edge.
  logic [31:0] mregs [32];
  logic [31:0] m_cnt;
  bit          m_tv;
  logic [31:0] m_tpc;
  logic [4:0]  m_taddr;
  logic [31:0] m_tdata;
  bit          known;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [4:0] ra, input bit byp,
                                           input bit rst_n, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
    if (byp && rst_n && we && wa == ra) return wd;
    return mregs[ra];
  endfunction

  // One clock cycle: drive both instances, predict reads for this cycle and
  // the post-edge state, then advance the model across the edge.
  task automatic do_cycle(input bit rst_n, input bit we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [31:0] pc,
                          input logic [4:0] ra1, input logic [4:0] ra2,
                          input bit preload);
    exp_t e;
    @(posedge clk);
    #1;
    if (preload) begin
      force u_b1.cnt_q = 32'hFFFF_FFFF;
      force u_b0.cnt_q = 32'hFFFF_FFFF;
      #1;
      release u_b1.cnt_q;
      release u_b0.cnt_q;
      m_cnt = 32'hFFFF_FFFF;
    end
    reset = rst_n;
    bus1.we = we; bus1.wa = wa; bus1.wd = wd; bus1.pc = pc; bus1.ra1 = ra1; bus1.ra2 = ra2;
    bus0.we = we; bus0.wa = wa; bus0.wd = wd; bus0.pc = pc; bus0.ra1 = ra1; bus0.ra2 = ra2;
    e.chk   = known;
    e.r1_b1 = model_rd(ra1, 1'b1, rst_n, we, wa, wd);
    e.r2_b1 = model_rd(ra2, 1'b1, rst_n, we, wa, wd);
    e.r1_b0 = model_rd(ra1, 1'b0, rst_n, we, wa, wd);
    e.r2_b0 = model_rd(ra2, 1'b0, rst_n, we, wa, wd);
    e.tv    = m_tv;
    e.tpc   = m_tpc;
    e.taddr = m_taddr;
    e.tdata = m_tdata;
    e.cnt   = m_cnt;
    expq.push_back(e);
    if (!rst_n) begin
      foreach (mregs[i]) mregs[i] = 32'd0;
      m_cnt = 0; m_tv = 0; m_tpc = 0; m_taddr = 0; m_tdata = 0;
      known = 1;
    end else begin
      m_tv = we;
      if (we) begin
        m_tpc   = pc;
        m_taddr = wa;
        m_tdata = (wa == 5'd0) ? 32'd0 : wd;
        if (wa != 5'd0) begin
          mregs[wa] = wd;
          m_cnt     = m_cnt + 32'd1;
        end
      end
    end
  endtask

  // Monitor: one expectation per cycle, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        if (e.chk) begin
          check("rd1_byp1", bus1.rd1, e.r1_b1);
          check("rd2_byp1", bus1.rd2, e.r2_b1);
          check("rd1_byp0", bus0.rd1, e.r1_b0);
          check("rd2_byp0", bus0.rd2, e.r2_b0);
          check("trace_valid", {31'd0, bus1.trace_valid}, {31'd0, e.tv});
          check("trace_pc", bus1.trace_pc, e.tpc);
          check("trace_addr", {27'd0, bus1.trace_addr}, {27'd0, e.taddr});
          check("trace_data", bus1.trace_data, e.tdata);
          check("wr_count", bus1.wr_count, e.cnt);
          check("trace_valid_b0", {31'd0, bus0.trace_valid}, {31'd0, e.tv});
          check("trace_data_b0", bus0.trace_data, e.tdata);
          check("wr_count_b0", bus0.wr_count, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [4:0]  wa, ra1, ra2;
    bit          we, rst_n;
    logic [31:0] wd;
    known = 0;
    m_cnt = 0; m_tv = 0; m_tpc = 0; m_taddr = 0; m_tdata = 0;
    foreach (mregs[i]) mregs[i] = 32'd0;
    reset = 1'b0;
    bus1.we = 0; bus1.wa = 0; bus1.wd = 0; bus1.pc = 0; bus1.ra1 = 0; bus1.ra2 = 0;
    bus0.we = 0; bus0.wa = 0; bus0.wd = 0; bus0.pc = 0; bus0.ra1 = 0; bus0.ra2 = 0;

    // reset, then idle reads
    do_cycle(0, 0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd31, 0);
    do_cycle(0, 0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd31, 0);
    do_cycle(1, 0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd31, 0);
    // forwarded write, then r0 write
    do_cycle(1, 1, 5'd8, 32'h1234_5678, 32'h3000, 5'd8, 5'd8, 0);
    do_cycle(1, 1, 5'd0, 32'hFFFF_FFFF, 32'h3004, 5'd0, 5'd8, 0);
    do_cycle(1, 0, 5'd0, 32'd0, 32'd0, 5'd8, 5'd0, 0);
    // jal link write, then reset with a competing write
    do_cycle(1, 1, 5'd31, 32'h3008, 32'h3008, 5'd31, 5'd31, 0);
    do_cycle(0, 1, 5'd31, 32'hDEAD, 32'h300C, 5'd31, 5'd31, 0);
    do_cycle(1, 0, 5'd0, 32'd0, 32'd0, 5'd31, 5'd8, 0);
    // old value before the edge on the non-forwarding instance
    do_cycle(1, 1, 5'd3, 32'd7, 32'h3010, 5'd0, 5'd3, 0);
    do_cycle(1, 0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3, 0);
    // back-to-back writes to one address, last wins; both ports forward
    do_cycle(1, 1, 5'd3, 32'd9, 32'h3014, 5'd3, 5'd3, 0);
    do_cycle(1, 1, 5'd3, 32'd10, 32'h3018, 5'd3, 5'd3, 0);
    do_cycle(1, 0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3, 0);
    // counter wrap
    do_cycle(1, 1, 5'd1, 32'h55, 32'h301C, 5'd1, 5'd2, 1);
    do_cycle(1, 0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd3, 0);

    // randomized traffic with address collisions and occasional reset
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      we    = ($urandom_range(0, 9) < 7);
      wa    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wd    = $urandom;
      ra1   = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7));
      ra2   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      do_cycle(rst_n, we, wa, wd, $urandom, ra1, ra2, 0);
    end

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      check("pending_expectations", expq.size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
